instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Sequential instruction-fetch front end for the LEGv8 datapath. It holds the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents each fetched 32-bit instruction to the Controller over a valid/ready handshake. It computes the next PC from the branch decision the Controller and ALU return for the instruction being accepted. It is the producer end of the Controller's instruction input.

## Interface
Parameters:
- RESET_PC, 64'h0, PC loaded at reset; bits [1:0] forced to 0.

Ports:
- clk  in  1  rising-edge clock.
- resetN  in  1  asynchronous, active-low reset.
- imemReq  out  1  fetch request to instruction memory.
- imemAddr  out  64  byte address of the fetch (current PC).
- imemAck  in  1  memory returns data on imemData this cycle.
- imemData  in  32  instruction word from memory.
- instrValid  out  1  instruction/instrPC valid for Controller.
- instruction  out  32  instruction word to Controller.
- instrPC  out  64  address of presented instruction.
- instrReady  in  1  Controller accepts the presented instruction.
- unconditionalBranch  in  1  from Controller, for the accepted instruction.
- branch  in  1  conditional branch (CBZ) flag from Controller.
- zeroFlag  in  1  ALU zero result for the accepted instruction.
- branchOffset  in  64  sign-extended word offset (imm26/imm19).
- halt  in  1  stop fetching after the accepted instruction.
- halted  out  1  unit is in HALT.

## Operation
- Four states: IDLE, FETCH, HOLD, HALT. Reset enters IDLE.
- IDLE: always moves to FETCH on the next clock.
- FETCH: imemReq=1 and imemAddr=pc (Moore).
  - If imemAck: instruction<=imemData, instrPC<=pc, then HOLD.
  - Otherwise stay in FETCH.
- HOLD: instrValid=1, with instruction and instrPC held stable.
  - If instrReady: pc<=nextPC, then HALT if halt=1, else FETCH.
  - Otherwise stay in HOLD.
- HALT: all handshakes idle and halted=1. Only reset exits HALT.
- taken = unconditionalBranch | (branch & zeroFlag).
- nextPC = taken ? instrPC + (branchOffset<<2) : instrPC + 4.
- All address arithmetic is modulo 2^64 (wrap-around, no fault). branchOffset<<2 discards the top 2 bits.
- Branch inputs and halt are sampled only in HOLD with instrReady=1. They are ignored in every other state.
- imemAck outside FETCH is ignored. imemData is ignored unless imemAck=1 in FETCH.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC.
  - imemReq=0, imemAddr=RESET_PC.
  - instrValid=0, instruction=0, instrPC=0, halted=0.
- Reset asserted at any point (mid-FETCH or mid-HOLD) abandons the transaction immediately. Any in-flight ack after reset release, before FETCH, is ignored.
- imemReq rises one cycle after reset release. imemAddr is stable while imemReq=1.
- Memory latency may be 0..N cycles; ack can arrive in the first FETCH cycle.
- With zero-wait memory and instrReady held high, the unit issues one instruction every 2 cycles:
  - FETCH cycle: imemReq=1.
  - HOLD cycle: instrValid=1, accepted.
  - Next cycle: FETCH at the new PC.
- instrValid rises the cycle after the ack cycle and stays high until the cycle after acceptance.
- The new imemAddr (nextPC) is visible the cycle after acceptance.
- halted rises the cycle after acceptance with halt=1.
- No combinational path from any input to any output. All outputs come from state or registers.

## Test plan
- Reset, RESET_PC=0x100, zero-wait memory, instrReady=1, no branches -> imemAddr 0x100, 0x104, 0x108 on alternate cycles; instrPC matches; instrValid high every 2nd cycle.
- imemAck delayed 3 cycles at 0x104 -> imemReq/imemAddr=0x104 held 4 cycles; instrValid the cycle after ack; instruction equals imemData.
- instrReady low 4 cycles in HOLD -> instruction/instrPC unchanged, imemReq=0; fetch resumes the cycle after the accept.
- Branch cases:
  - At instrPC 0x108, unconditionalBranch=1, offset=-2 -> next imemAddr 0x100.
  - branch=1, zeroFlag=0 -> +4.
  - branch=1, zeroFlag=1, offset=5 -> instrPC+0x14.
- Wrap: RESET_PC=0xFFFF_FFFF_FFFF_FFFC, no branch -> second fetch at 0x0. RESET_PC=0x103 -> first fetch at 0x100.
- Reset and halt:
  - resetN pulsed low mid-FETCH with a pending late ack -> outputs return to reset values; ack ignored; refetch from RESET_PC.
  - halt=1 at accept -> halted=1, imemReq stays 0 for 10 cycles.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: the instruction-memory req/ack port, the Controller valid/ready
// port, the branch feedback for the accepted instruction, and the halt status.
interface instruction_fetch_unit_if;
  logic        imemReq;
  logic [63:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        instrValid;
  logic [31:0] instruction;
  logic [63:0] instrPC;
  logic        instrReady;
  logic        unconditionalBranch;
  logic        branch;
  logic        zeroFlag;
  logic [63:0] branchOffset;
  logic        halt;
  logic        halted;

  modport master (
    output imemReq, imemAddr, instrValid, instruction, instrPC, halted,
    input  imemAck, imemData, instrReady, unconditionalBranch, branch,
           zeroFlag, branchOffset, halt
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instruction, instrPC, halted,
    output imemAck, imemData, instrReady, unconditionalBranch, branch,
           zeroFlag, branchOffset, halt
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// LEGv8 fetch front end: holds the PC, fetches one word per request, presents it
// to the Controller and steps the PC using the branch outcome at acceptance.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                          clk,
  input  logic                          resetN,
  instruction_fetch_unit_if.master      bus
);
  localparam logic [63:0] RESET_PC_ALIGNED = {RESET_PC[63:2], 2'b00};

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state, stateNext;
  logic [63:0] pc;
  logic [63:0] instrPCq;
  logic [31:0] instrQ;
  logic        ackTaken;
  logic        accept;
  logic        taken;
  logic [63:0] nextPC;

  assign ackTaken = (state == FETCH) && bus.imemAck;
  assign accept   = (state == HOLD) && bus.instrReady;
  assign taken    = bus.unconditionalBranch | (bus.branch & bus.zeroFlag);
  // The shift drops the offset's top two bits; the add wraps modulo 2^64.
  assign nextPC   = taken ? instrPCq + {bus.branchOffset[61:0], 2'b00}
                          : instrPCq + 64'd4;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = FETCH;
      FETCH:   if (bus.imemAck) stateNext = HOLD;
      HOLD:    if (bus.instrReady) stateNext = bus.halt ? HALT : FETCH;
      HALT:    stateNext = HALT;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pc       <= RESET_PC_ALIGNED;
      instrQ   <= 32'h0;
      instrPCq <= 64'h0;
    end else begin
      if (ackTaken) begin
        instrQ   <= bus.imemData;
        instrPCq <= pc;
      end
      if (accept) pc <= nextPC;
    end
  end

  // Every output is a decode of the state register or a register itself.
  assign bus.imemReq     = (state == FETCH);
  assign bus.imemAddr    = pc;
  assign bus.instrValid  = (state == HOLD);
  assign bus.instruction = instrQ;
  assign bus.instrPC     = instrPCq;
  assign bus.halted      = (state == HALT);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of instruction_fetch_unit against a
// transaction-level PC model.
module tb_instruction_fetch_unit;
  logic clk;
  logic rst0, rst1, rst2;
  int   tests = 0;
  int   fails = 0;
  logic [63:0] expPc;

  instruction_fetch_unit_if ifc0();
  instruction_fetch_unit_if ifc1();
  instruction_fetch_unit_if ifc2();

  instruction_fetch_unit #(.RESET_PC(64'h100)) dut0 (
    .clk(clk), .resetN(rst0), .bus(ifc0.master));
  instruction_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
    .clk(clk), .resetN(rst1), .bus(ifc1.master));
  instruction_fetch_unit #(.RESET_PC(64'h103)) dut2 (
    .clk(clk), .resetN(rst2), .bus(ifc2.master));

  // Wrap/alignment units see an always-ready, zero-wait environment.
  assign ifc1.imemAck = 1'b1;
  assign ifc1.imemData = 32'hA5A5_0001;
  assign ifc1.instrReady = 1'b1;
  assign ifc1.unconditionalBranch = 1'b0;
  assign ifc1.branch = 1'b0;
  assign ifc1.zeroFlag = 1'b0;
  assign ifc1.branchOffset = 64'h0;
  assign ifc1.halt = 1'b0;
  assign ifc2.imemAck = 1'b1;
  assign ifc2.imemData = 32'hA5A5_0002;
  assign ifc2.instrReady = 1'b1;
  assign ifc2.unconditionalBranch = 1'b0;
  assign ifc2.branch = 1'b0;
  assign ifc2.zeroFlag = 1'b0;
  assign ifc2.branchOffset = 64'h0;
  assign ifc2.halt = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, ".imemReq"},     64'(ifc0.imemReq),     64'h0);
    check({tag, ".imemAddr"},    ifc0.imemAddr,         64'h100);
    check({tag, ".instrValid"},  64'(ifc0.instrValid),  64'h0);
    check({tag, ".instruction"}, 64'(ifc0.instruction), 64'h0);
    check({tag, ".instrPC"},     ifc0.instrPC,          64'h0);
    check({tag, ".halted"},      64'(ifc0.halted),      64'h0);
  endtask

  // One full transaction on dut0, entered and left with the unit in FETCH.
  task automatic fetchOne(input int lat, input logic [31:0] data, input int rdyDly,
                          input logic ub, input logic br, input logic zf,
                          input logic [63:0] off, input logic hlt);
    for (int k = 0; k < lat; k++) begin
      check("waitReq",  64'(ifc0.imemReq), 64'h1);
      check("waitAddr", ifc0.imemAddr, expPc);
      ifc0.imemAck = 1'b0;
      ifc0.imemData = $urandom;
      ifc0.instrReady = 1'($urandom);
      step();
    end
    check("ackReq",   64'(ifc0.imemReq), 64'h1);
    check("ackAddr",  ifc0.imemAddr, expPc);
    check("ackValid", 64'(ifc0.instrValid), 64'h0);
    ifc0.imemAck = 1'b1;
    ifc0.imemData = data;
    ifc0.instrReady = 1'($urandom);
    step();
    ifc0.imemAck = 1'($urandom);
    ifc0.imemData = $urandom;
    for (int k = 0; k <= rdyDly; k++) begin
      check("holdValid", 64'(ifc0.instrValid), 64'h1);
      check("holdInstr", 64'(ifc0.instruction), 64'(data));
      check("holdPC",    ifc0.instrPC, expPc);
      check("holdReq",   64'(ifc0.imemReq), 64'h0);
      if (k < rdyDly) begin
        ifc0.instrReady = 1'b0;
        ifc0.unconditionalBranch = 1'($urandom);
        ifc0.branch = 1'($urandom);
        ifc0.zeroFlag = 1'($urandom);
        ifc0.branchOffset = {$urandom, $urandom};
        ifc0.halt = 1'($urandom);
      end else begin
        ifc0.instrReady = 1'b1;
        ifc0.unconditionalBranch = ub;
        ifc0.branch = br;
        ifc0.zeroFlag = zf;
        ifc0.branchOffset = off;
        ifc0.halt = hlt;
      end
      step();
    end
    ifc0.instrReady = 1'b0;
    ifc0.halt = 1'b0;
    ifc0.imemAck = 1'b0;
    if (ub || (br && zf)) expPc = expPc + off * 64'd4;
    else                  expPc = expPc + 64'd4;
    if (hlt) begin
      check("haltFlag", 64'(ifc0.halted), 64'h1);
      check("haltReq",  64'(ifc0.imemReq), 64'h0);
    end else begin
      check("nextReq",   64'(ifc0.imemReq), 64'h1);
      check("nextAddr",  ifc0.imemAddr, expPc);
      check("nextValid", 64'(ifc0.instrValid), 64'h0);
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    ifc0.imemAck = 1'b0; ifc0.imemData = 32'h0; ifc0.instrReady = 1'b0;
    ifc0.unconditionalBranch = 1'b0; ifc0.branch = 1'b0; ifc0.zeroFlag = 1'b0;
    ifc0.branchOffset = 64'h0; ifc0.halt = 1'b0;
    step();
    step();
    checkResetValues("reset");
    check("wrapResetAddr",  ifc1.imemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("alignResetAddr", ifc2.imemAddr, 64'h100);

    // Wrap-around and alignment on the fixed-environment units.
    rst1 = 1'b1; rst2 = 1'b1;
    step();
    check("wrapReq1",   64'(ifc1.imemReq), 64'h1);
    check("wrapAddr1",  ifc1.imemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("alignReq",   64'(ifc2.imemReq), 64'h1);
    check("alignAddr",  ifc2.imemAddr, 64'h100);
    step();
    check("wrapValid",  64'(ifc1.instrValid), 64'h1);
    check("wrapPC",     ifc1.instrPC, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrapInstr",  64'(ifc1.instruction), 64'hA5A5_0001);
    step();
    check("wrapAddr2",  ifc1.imemAddr, 64'h0);
    check("wrapReq2",   64'(ifc1.imemReq), 64'h1);
    check("alignAddr2", ifc2.imemAddr, 64'h104);

    // Directed sequence on dut0.
    rst0 = 1'b1;
    expPc = 64'h100;
    step();
    check("firstReq", 64'(ifc0.imemReq), 64'h1);
    fetchOne(0, 32'h1111_0000, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    fetchOne(3, 32'h2222_0004, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    fetchOne(0, 32'h3333_0008, 0, 1'b1, 1'b0, 1'b0, -64'sd2, 1'b0);
    check("ubTarget", expPc, 64'h100);
    fetchOne(0, 32'h4444_0100, 4, 1'b0, 1'b1, 1'b0, 64'h7, 1'b0);
    fetchOne(1, 32'h5555_0104, 0, 1'b0, 1'b1, 1'b1, 64'h5, 1'b0);
    check("cbzTarget", expPc, 64'h118);

    // Randomized transactions.
    for (int n = 0; n < 25; n++) begin
      fetchOne(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
               {$urandom, $urandom}, 1'b0);
    end

    // Reset mid-FETCH with a late ack arriving around the release.
    ifc0.imemAck = 1'b0;
    step();
    check("preResetReq", 64'(ifc0.imemReq), 64'h1);
    rst0 = 1'b0;
    #1;
    checkResetValues("midReset");
    ifc0.imemAck = 1'b1;
    ifc0.imemData = 32'hDEAD_BEEF;
    step();
    step();
    rst0 = 1'b1;
    step();
    check("postResetValid", 64'(ifc0.instrValid), 64'h0);
    check("postResetInstr", 64'(ifc0.instruction), 64'h0);
    check("postResetReq",   64'(ifc0.imemReq), 64'h1);
    check("postResetAddr",  ifc0.imemAddr, 64'h100);
    ifc0.imemAck = 1'b0;
    expPc = 64'h100;
    fetchOne(2, 32'h6666_0100, 1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);

    // Halt at accept, then nothing may wake the unit.
    fetchOne(0, 32'h7777_0104, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      ifc0.imemAck = 1'($urandom);
      ifc0.instrReady = 1'b1;
      step();
      check("haltedReq",   64'(ifc0.imemReq), 64'h0);
      check("haltedFlag",  64'(ifc0.halted), 64'h1);
      check("haltedValid", 64'(ifc0.instrValid), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
